// File: rtl/decode_issue_pkg.sv
// Shared definitions for the decode/operand-fetch stage: instruction layout,
// opcode values and the opcode classification used for hazard checking.
package decode_issue_pkg;

   localparam int INSTR_W = 16;

   // Instruction field positions: {op, rd, rs1, rs2}, LDI immediate in the low byte
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int RS1_HI = 7;
   localparam int RS1_LO = 4;
   localparam int RS2_HI = 3;
   localparam int RS2_LO = 0;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_SLL  = 4'h6;
   localparam logic [3:0] OP_SRL  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_NOP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef struct packed {
      logic usesRs1;
      logic usesRs2;
      logic writesRd;
      logic isNop;
      logic isHalt;
      logic isIllegal;
   } opClass_t;

   // NOP, HALT and undefined opcodes touch no registers, so they can never hazard
   function automatic opClass_t classifyOp(input logic [3:0] op);
      opClass_t c;
      c = '0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
            c.usesRs1  = 1'b1;
            c.usesRs2  = 1'b1;
            c.writesRd = 1'b1;
         end
         OP_NOT: begin
            c.usesRs1  = 1'b1;
            c.writesRd = 1'b1;
         end
         OP_LDI:  c.writesRd  = 1'b1;
         OP_NOP:  c.isNop     = 1'b1;
         OP_HALT: c.isHalt    = 1'b1;
         default: c.isIllegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Bus bundle around the decode stage: fetch handshake, register-file read and
// scoreboard lines, and the issue handshake toward execute.
interface decode_issue_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
);
   import decode_issue_pkg::*;

   logic               if_valid;
   logic [INSTR_W-1:0] if_instr;
   logic               if_ready;

   logic [REG_AW-1:0]  rf_src1;
   logic [REG_AW-1:0]  rf_src2;
   logic [REG_AW-1:0]  rf_dest;
   logic [DATA_W-1:0]  rf_val1;
   logic [DATA_W-1:0]  rf_val2;
   logic               rf_inuse1;
   logic               rf_inuse2;
   logic               rf_inuse_d;
   logic               rf_claim;

   logic               ex_valid;
   logic               ex_ready;
   logic [3:0]         ex_op;
   logic [REG_AW-1:0]  ex_dest;
   logic [DATA_W-1:0]  ex_a;
   logic [DATA_W-1:0]  ex_b;

   // The decode stage itself
   modport slave (
      input  if_valid, if_instr, rf_val1, rf_val2, rf_inuse1, rf_inuse2, rf_inuse_d, ex_ready,
      output if_ready, rf_src1, rf_src2, rf_dest, rf_claim,
      output ex_valid, ex_op, ex_dest, ex_a, ex_b
   );

   // Surrounding pipeline: fetch, register file and execute
   modport master (
      output if_valid, if_instr, rf_val1, rf_val2, rf_inuse1, rf_inuse2, rf_inuse_d, ex_ready,
      input  if_ready, rf_src1, rf_src2, rf_dest, rf_claim,
      input  ex_valid, ex_op, ex_dest, ex_a, ex_b
   );

endinterface

// File: rtl/decode_issue_classify.sv
// Purely combinational opcode classifier feeding the hazard and issue logic.
module decode_classify
   import decode_issue_pkg::*;
(
   input  logic [3:0] op,
   output logic       usesRs1,
   output logic       usesRs2,
   output logic       writesRd,
   output logic       isNop,
   output logic       isHalt,
   output logic       isIllegal
);

   opClass_t cls;

   assign cls       = classifyOp(op);
   assign usesRs1   = cls.usesRs1;
   assign usesRs2   = cls.usesRs2;
   assign writesRd  = cls.writesRd;
   assign isNop     = cls.isNop;
   assign isHalt    = cls.isHalt;
   assign isIllegal = cls.isIllegal;

endmodule

// File: rtl/decode_issue.sv
// Decode/operand-fetch stage: one-entry decode buffer, scoreboard hazard check,
// and an output register handed to execute over valid/ready.
module decode_issue
   import decode_issue_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int REG_AW  = 4,
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   decode_issue_if.slave      bus,
   output logic               halted,
   output logic               illegal,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   logic [0:0]         state;
   logic               bufValid;
   logic [INSTR_W-1:0] bufInstr;
   logic [3:0]         bufOp;

   logic               usesRs1;
   logic               usesRs2;
   logic               writesRd;
   logic               isNop;
   logic               isHalt;
   logic               isIllegal;

   logic               hazard;
   logic               issue;
   logic               accept;
   logic               passThrough;
   logic               loadEx;

   logic               exValid;
   logic [3:0]         exOp;
   logic [REG_AW-1:0]  exDest;
   logic [DATA_W-1:0]  exA;
   logic [DATA_W-1:0]  exB;
   logic               illegalSeen;
   logic [STALL_W-1:0] stallCnt;

   assign bufOp = bufInstr[OP_HI:OP_LO];

   decode_classify classify (
      .op        (bufOp),
      .usesRs1   (usesRs1),
      .usesRs2   (usesRs2),
      .writesRd  (writesRd),
      .isNop     (isNop),
      .isHalt    (isHalt),
      .isIllegal (isIllegal)
   );

   // Register-file addresses come straight from the buffered instruction
   assign bus.rf_src1 = REG_AW'(bufInstr[RS1_HI:RS1_LO]);
   assign bus.rf_src2 = REG_AW'(bufInstr[RS2_HI:RS2_LO]);
   assign bus.rf_dest = REG_AW'(bufInstr[RD_HI:RD_LO]);

   // Scoreboard check; the WAW term keeps at most one writer in flight per register
   always_comb begin
      hazard = (usesRs1 && bus.rf_inuse1) || (usesRs2 && bus.rf_inuse2) ||
               (writesRd && bus.rf_inuse_d);
   end

   // Issue needs a clean buffer and a free (or draining) output register
   always_comb begin
      issue       = bufValid && !hazard && (!exValid || bus.ex_ready);
      accept      = bus.if_valid && bus.if_ready;
      passThrough = isNop || isIllegal;
      loadEx      = issue && !passThrough && !isHalt;
   end

   assign bus.if_ready = (state == ST_RUN) && (!bufValid || issue);
   assign bus.rf_claim = rst_n && issue && writesRd;

   // Decode buffer: refills on accept, empties when its instruction issues
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bufValid <= 1'b0;
         bufInstr <= '0;
      end else if (accept) begin
         bufValid <= 1'b1;
         bufInstr <= bus.if_instr;
      end else if (issue) begin
         bufValid <= 1'b0;
      end
   end

   // Output register: loads on a writer issue, holds under backpressure, clears once drained
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exValid <= 1'b0;
         exOp    <= '0;
         exDest  <= '0;
         exA     <= '0;
         exB     <= '0;
      end else if (loadEx) begin
         exValid <= 1'b1;
         exOp    <= bufOp;
         exDest  <= REG_AW'(bufInstr[RD_HI:RD_LO]);
         if (bufOp == OP_LDI) begin
            exA <= '0;
            exB <= {{(DATA_W-8){1'b0}}, bufInstr[IMM_HI:IMM_LO]};
         end else begin
            exA <= bus.rf_val1;
            exB <= usesRs2 ? bus.rf_val2 : '0;
         end
      end else if (exValid && bus.ex_ready) begin
         exValid <= 1'b0;
      end
   end

   // HALT parks the stage until reset; nothing else leaves the HALTED state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else if (issue && isHalt) begin
         state <= ST_HALTED;
      end
   end

   // Sticky flag for any undefined opcode that reached issue
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegalSeen <= 1'b0;
      end else if (issue && isIllegal) begin
         illegalSeen <= 1'b1;
      end
   end

   // Counts only hazard stalls, not cycles lost to execute backpressure
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt <= '0;
      end else if (bufValid && hazard && (stallCnt != '1)) begin
         stallCnt <= stallCnt + STALL_W'(1);
      end
   end

   assign bus.ex_valid = exValid;
   assign bus.ex_op    = exOp;
   assign bus.ex_dest  = exDest;
   assign bus.ex_a     = exA;
   assign bus.ex_b     = exB;
   assign halted       = (state == ST_HALTED);
   assign illegal      = illegalSeen;
   assign stall_cnt    = stallCnt;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: a register-file/scoreboard model
// drives the rf_* inputs, and expected issues/claims are queued at accept time.
module tb_decode_issue;
   import decode_issue_pkg::*;

   localparam int DATA_W  = 16;
   localparam int REG_AW  = 4;
   localparam int STALL_W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic halted;
   logic illegal;
   logic [STALL_W-1:0] stall_cnt;

   always #5 clk = ~clk;

   decode_issue_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

   decode_issue #(.DATA_W(DATA_W), .REG_AW(REG_AW), .STALL_W(STALL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .halted    (halted),
      .illegal   (illegal),
      .stall_cnt (stall_cnt)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  dest;
      logic [15:0] a;
      logic [15:0] b;
   } exTxn_t;

   exTxn_t     expEx[$];
   logic [3:0] expClaim[$];

   int checks = 0;
   int errors = 0;
   int monChecks = 0;
   int monErrors = 0;
   int stallExp = 0;

   logic [15:0] busy;
   logic [15:0] busyNext;
   logic [15:0] wbMask = '0;
   logic        wbReq = 1'b0;
   logic        holdWb = 1'b0;
   logic        forceInuse1 = 1'b0;
   logic        forceInuse2 = 1'b0;
   logic        forceInuseD = 1'b0;

   exTxn_t     monGot;
   exTxn_t     monExp;
   logic [3:0] monDest;

   function automatic logic [15:0] regVal(input logic [3:0] r);
      return {r, 4'hC, ~r, 4'h3};
   endfunction

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
      return {op, rd, rs1, rs2};
   endfunction

   // Register-file model: values are a fixed function of the address, inuse comes from busy
   always_comb begin
      bus.rf_val1    = regVal(bus.rf_src1);
      bus.rf_val2    = regVal(bus.rf_src2);
      bus.rf_inuse1  = busy[bus.rf_src1] | forceInuse1;
      bus.rf_inuse2  = busy[bus.rf_src2] | forceInuse2;
      bus.rf_inuse_d = busy[bus.rf_dest] | forceInuseD;
   end

   // Scoreboard model: claim sets, execute handoff clears unless writeback is held
   always_comb begin
      busyNext = busy;
      if (bus.ex_valid && bus.ex_ready && !holdWb) busyNext[bus.ex_dest] = 1'b0;
      if (wbReq) busyNext = busyNext & ~wbMask;
      if (bus.rf_claim) busyNext[bus.rf_dest] = 1'b1;
   end

   always @(posedge clk) begin
      busy <= rst_n ? busyNext : '0;
   end

   // Monitor: every execute handoff and every claim must match the queued expectation
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         if (bus.rf_claim) begin
            monChecks++;
            monErrors++;
            $display("[TB] FAIL claim_in_reset: rf_claim=1 dest=%h, required 0", bus.rf_dest);
         end
      end else begin
         if (bus.ex_valid && bus.ex_ready) begin
            monChecks++;
            monGot = {bus.ex_op, bus.ex_dest, bus.ex_a, bus.ex_b};
            if (expEx.size() == 0) begin
               monErrors++;
               $display("[TB] FAIL ex_unexpected: op=%h dest=%h a=%h b=%h, required no output",
                        monGot.op, monGot.dest, monGot.a, monGot.b);
            end else begin
               monExp = expEx.pop_front();
               if (monGot !== monExp) begin
                  monErrors++;
                  $display("[TB] FAIL ex_txn: got op=%h dest=%h a=%h b=%h, required op=%h dest=%h a=%h b=%h",
                           monGot.op, monGot.dest, monGot.a, monGot.b,
                           monExp.op, monExp.dest, monExp.a, monExp.b);
               end
            end
         end
         if (bus.rf_claim) begin
            monChecks++;
            if (expClaim.size() == 0) begin
               monErrors++;
               $display("[TB] FAIL claim_unexpected: dest=%h, required no claim", bus.rf_dest);
            end else begin
               monDest = expClaim.pop_front();
               if (bus.rf_dest !== monDest) begin
                  monErrors++;
                  $display("[TB] FAIL claim_dest: got %h, required %h", bus.rf_dest, monDest);
               end
            end
            monChecks++;
            if (busy[bus.rf_dest] !== 1'b0) begin
               monErrors++;
               $display("[TB] FAIL double_claim: reg %h already in use (busy=%b), required free",
                        bus.rf_dest, busy[bus.rf_dest]);
            end
         end
      end
   end

   // Expected execute transaction and claim for an accepted writer instruction
   task automatic pushExpected(input logic [15:0] instr);
      exTxn_t e;
      logic [3:0] op;
      op = instr[15:12];
      if (op <= 4'h8) begin
         e.op   = op;
         e.dest = instr[11:8];
         e.a    = (op == OP_LDI) ? 16'h0000 : regVal(instr[7:4]);
         if (op == OP_LDI)      e.b = {8'h00, instr[7:0]};
         else if (op == OP_NOT) e.b = 16'h0000;
         else                   e.b = regVal(instr[3:0]);
         expEx.push_back(e);
         expClaim.push_back(instr[11:8]);
      end
   endtask

   // Offer one instruction and wait (bounded) until the stage takes it
   task automatic applyStimulus(input logic [15:0] instr);
      int waitCycles;
      waitCycles = 0;
      bus.if_valid = 1'b1;
      bus.if_instr = instr;
      @(negedge clk);
      while (!bus.if_ready && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      checks++;
      if (!bus.if_ready) begin
         errors++;
         $display("[TB] FAIL accept_timeout: if_ready=%b after %0d cycles, required 1", bus.if_ready, waitCycles);
      end
      @(posedge clk);
      #1;
      bus.if_valid = 1'b0;
      if (bus.if_ready === 1'b1 || waitCycles < 50) pushExpected(instr);
   endtask

   task automatic idle(input int n);
      bus.if_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      bus.if_valid = 1'b0;
      bus.ex_ready = 1'b1;
      holdWb = 1'b0;
      wbReq = 1'b0;
      forceInuse1 = 1'b0;
      forceInuse2 = 1'b0;
      forceInuseD = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      expEx.delete();
      expClaim.delete();
      stallExp = 0;
   endtask

   // Reset values, observed while reset is still held
   task automatic test_reset();
      rst_n = 1'b0;
      bus.if_valid = 1'b0;
      bus.if_instr = '0;
      bus.ex_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_valid: got %b, required 0", bus.ex_valid); end
      checks++; if ({bus.ex_op, bus.ex_dest, bus.ex_a, bus.ex_b} !== 40'h0) begin errors++; $display("[TB] FAIL reset_ex_fields: got op=%h dest=%h a=%h b=%h, required all 0", bus.ex_op, bus.ex_dest, bus.ex_a, bus.ex_b); end
      checks++; if (bus.rf_claim !== 1'b0) begin errors++; $display("[TB] FAIL reset_claim: got %b, required 0", bus.rf_claim); end
      checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got halted=%b illegal=%b, required 0 0", halted, illegal); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0d, required 0", stall_cnt); end
      checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_if_ready: got %b, required 1", bus.if_ready); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ADD r3,r1,r2 then SUB r4,r5,r6 back to back with no hazards
   task automatic test_stream();
      bus.if_valid = 1'b1;
      bus.if_instr = mk(OP_ADD, 4'd3, 4'd1, 4'd2);
      @(negedge clk);
      checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready: got %b, required 1", bus.if_ready); end
      @(posedge clk); #1;
      pushExpected(mk(OP_ADD, 4'd3, 4'd1, 4'd2));
      bus.if_instr = mk(OP_SUB, 4'd4, 4'd5, 4'd6);
      @(negedge clk);
      checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_early_valid: got %b, required 0", bus.ex_valid); end
      checks++; if ({bus.rf_claim, bus.rf_dest} !== {1'b1, 4'd3}) begin errors++; $display("[TB] FAIL stream_claim1: got claim=%b dest=%h, required 1 3", bus.rf_claim, bus.rf_dest); end
      @(posedge clk); #1;
      pushExpected(mk(OP_SUB, 4'd4, 4'd5, 4'd6));
      bus.if_valid = 1'b0;
      @(negedge clk);
      checks++; if ({bus.ex_valid, bus.ex_dest} !== {1'b1, 4'd3}) begin errors++; $display("[TB] FAIL stream_ex1: got valid=%b dest=%h, required 1 3", bus.ex_valid, bus.ex_dest); end
      checks++; if ({bus.rf_claim, bus.rf_dest} !== {1'b1, 4'd4}) begin errors++; $display("[TB] FAIL stream_claim2: got claim=%b dest=%h, required 1 4", bus.rf_claim, bus.rf_dest); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({bus.ex_valid, bus.ex_dest} !== {1'b1, 4'd4}) begin errors++; $display("[TB] FAIL stream_ex2: got valid=%b dest=%h, required 1 4", bus.ex_valid, bus.ex_dest); end
      idle(3);
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stream_stall: got %0d, required 0", stall_cnt); end
   endtask

   // RAW: rs1 busy for four cycles, then issue on the first free cycle
   task automatic test_raw_hazard();
      forceInuse1 = 1'b1;
      applyStimulus(mk(OP_ADD, 4'd3, 4'd1, 4'd2));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if ({bus.if_ready, bus.rf_claim, bus.ex_valid} !== 3'b000) begin errors++; $display("[TB] FAIL raw_stall%0d: got ready=%b claim=%b ex_valid=%b, required 0 0 0", i, bus.if_ready, bus.rf_claim, bus.ex_valid); end
         @(posedge clk); #1;
      end
      stallExp += 4;
      forceInuse1 = 1'b0;
      @(negedge clk);
      checks++; if (bus.rf_claim !== 1'b1) begin errors++; $display("[TB] FAIL raw_release: got claim=%b, required 1", bus.rf_claim); end
      checks++; if (stall_cnt !== 16'(stallExp)) begin errors++; $display("[TB] FAIL raw_stall_cnt: got %0d, required %0d", stall_cnt, stallExp); end
      idle(4);
   endtask

   // WAW: XOR r3 waits while the earlier ADD r3 has not written back
   task automatic test_waw();
      holdWb = 1'b1;
      applyStimulus(mk(OP_ADD, 4'd3, 4'd1, 4'd2));
      applyStimulus(mk(OP_XOR, 4'd3, 4'd1, 4'd2));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (bus.rf_claim !== 1'b0) begin errors++; $display("[TB] FAIL waw_wait%0d: got claim=%b, required 0", i, bus.rf_claim); end
         @(posedge clk); #1;
      end
      wbMask = 16'h0008;
      wbReq = 1'b1;
      @(posedge clk); #1;
      wbReq = 1'b0;
      holdWb = 1'b0;
      stallExp += 6;
      @(negedge clk);
      checks++; if ({bus.rf_claim, bus.rf_dest} !== {1'b1, 4'd3}) begin errors++; $display("[TB] FAIL waw_release: got claim=%b dest=%h, required 1 3", bus.rf_claim, bus.rf_dest); end
      checks++; if (stall_cnt !== 16'(stallExp)) begin errors++; $display("[TB] FAIL waw_stall_cnt: got %0d, required %0d", stall_cnt, stallExp); end
      idle(4);
   endtask

   // Backpressure with a full buffer: output stable, no hazard counting
   task automatic test_back_to_back();
      bus.ex_ready = 1'b0;
      applyStimulus(mk(OP_OR, 4'd5, 4'd1, 4'd2));
      applyStimulus(mk(OP_AND, 4'd6, 4'd7, 4'd8));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if ({bus.ex_valid, bus.ex_op, bus.ex_dest, bus.ex_a, bus.ex_b} !== {1'b1, OP_OR, 4'd5, regVal(4'd1), regVal(4'd2)}) begin
            errors++; $display("[TB] FAIL bp_hold%0d: got valid=%b op=%h dest=%h a=%h b=%h, required 1 3 5 %h %h", i, bus.ex_valid, bus.ex_op, bus.ex_dest, bus.ex_a, bus.ex_b, regVal(4'd1), regVal(4'd2));
         end
         checks++; if ({bus.if_ready, bus.rf_claim} !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready%0d: got ready=%b claim=%b, required 0 0", i, bus.if_ready, bus.rf_claim); end
         checks++; if (stall_cnt !== 16'(stallExp)) begin errors++; $display("[TB] FAIL bp_stall%0d: got %0d, required %0d", i, stall_cnt, stallExp); end
         @(posedge clk); #1;
      end
      bus.ex_ready = 1'b1;
      idle(4);
   endtask

   // LDI immediate, then HALT blocks all further fetch while the output drains
   task automatic test_ldi_halt();
      applyStimulus(16'h87A5);
      applyStimulus({OP_HALT, 12'h000});
      @(negedge clk);
      checks++; if ({bus.ex_valid, bus.ex_dest, bus.ex_a, bus.ex_b} !== {1'b1, 4'd7, 16'h0000, 16'h00A5}) begin errors++; $display("[TB] FAIL ldi_out: got valid=%b dest=%h a=%h b=%h, required 1 7 0000 00a5", bus.ex_valid, bus.ex_dest, bus.ex_a, bus.ex_b); end
      checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_early: got %b, required 0", halted); end
      @(posedge clk); #1;
      bus.if_valid = 1'b1;
      bus.if_instr = mk(OP_ADD, 4'd1, 4'd2, 4'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if ({halted, bus.if_ready} !== 2'b10) begin errors++; $display("[TB] FAIL halted%0d: got halted=%b if_ready=%b, required 1 0", i, halted, bus.if_ready); end
         @(posedge clk); #1;
      end
      bus.if_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_drain: got ex_valid=%b, required 0", bus.ex_valid); end
      @(posedge clk); #1;
   endtask

   // NOP passes silently; undefined opcode sets the sticky flag, no output
   task automatic test_illegal();
      doReset();
      @(negedge clk);
      checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b, required 0", halted); end
      @(posedge clk); #1;
      applyStimulus({OP_NOP, 12'h000});
      @(negedge clk);
      checks++; if (bus.rf_claim !== 1'b0) begin errors++; $display("[TB] FAIL nop_claim: got %b, required 0", bus.rf_claim); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({illegal, bus.ex_valid} !== 2'b00) begin errors++; $display("[TB] FAIL nop_out: got illegal=%b ex_valid=%b, required 0 0", illegal, bus.ex_valid); end
      @(posedge clk); #1;
      applyStimulus(16'hB123);
      @(negedge clk);
      checks++; if (bus.rf_claim !== 1'b0) begin errors++; $display("[TB] FAIL illegal_claim: got %b, required 0", bus.rf_claim); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({illegal, bus.ex_valid} !== 2'b10) begin errors++; $display("[TB] FAIL illegal_out: got illegal=%b ex_valid=%b, required 1 0", illegal, bus.ex_valid); end
      idle(2);
   endtask

   // Reset while both the buffer and output register are full
   task automatic test_reset_mid();
      bus.ex_ready = 1'b0;
      applyStimulus(mk(OP_ADD, 4'd1, 4'd2, 4'd3));
      applyStimulus(mk(OP_SUB, 4'd2, 4'd4, 4'd5));
      @(negedge clk);
      checks++; if ({bus.ex_valid, bus.if_ready} !== 2'b10) begin errors++; $display("[TB] FAIL mid_full: got ex_valid=%b if_ready=%b, required 1 0", bus.ex_valid, bus.if_ready); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.ex_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.rf_claim !== 1'b0) begin errors++; $display("[TB] FAIL mid_claim: got %b, required 0", bus.rf_claim); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({bus.ex_valid, bus.if_ready, bus.rf_claim, halted, illegal} !== 5'b01000) begin
         errors++; $display("[TB] FAIL mid_after: got ex_valid=%b if_ready=%b claim=%b halted=%b illegal=%b, required 0 1 0 0 0", bus.ex_valid, bus.if_ready, bus.rf_claim, halted, illegal);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      expEx.delete();
      expClaim.delete();
      applyStimulus(mk(OP_NOT, 4'd9, 4'd10, 4'd0));
      idle(4);
   endtask

   initial begin
      bus.if_valid = 1'b0;
      bus.if_instr = '0;
      bus.ex_ready = 1'b1;
      test_reset();
      test_stream();
      test_raw_hazard();
      test_waw();
      test_back_to_back();
      test_ldi_halt();
      test_illegal();
      test_reset_mid();
      checks++; if (expEx.size() != 0) begin errors++; $display("[TB] FAIL ex_leftover: %0d pending, required 0", expEx.size()); end
      checks++; if (expClaim.size() != 0) begin errors++; $display("[TB] FAIL claim_leftover: %0d pending, required 0", expClaim.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks + monChecks, errors + monErrors);
      $finish;
   end

   // Watchdog so a wedged DUT still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
